// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped, read-only instruction cache on the fetch side.
// A hit returns the stored word combinationally. A miss stalls fetch/decode
// and refills the whole line from backing memory over a req/ack handshake.
// Optional feature macro: ICACHE_PERF_EN (hit/miss performance counters).
module icache_fetch #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pcF,
   input  logic        inv,
   output logic [31:0] instrF,
   output logic        icstall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);
   localparam int OW = $clog2(WORDS);
   localparam int IW = $clog2(LINES);
   localparam int TW = 32 - OW - IW - 2;

   typedef enum logic {IDLE, FILL} state_t;

   state_t            state_q, state_d;
   logic [LINES-1:0]  valid_q;
   logic [TW-1:0]     tag_q  [LINES];
   logic [31:0]       data_q [LINES][WORDS];
   logic [31:0]       base_q, base_d;
   logic [OW-1:0]     k_q, k_d;
   logic              poison_q, poison_d;

   logic [OW-1:0]     pc_off;
   logic [IW-1:0]     pc_idx;
   logic [TW-1:0]     pc_tag;
   logic [IW-1:0]     fill_idx;
   logic [TW-1:0]     fill_tag;
   logic              hit;
   logic              fill_ack;
   logic              fill_done;
   logic              unused_pc;

   assign pc_off    = pcF[OW+1:2];
   assign pc_idx    = pcF[OW+IW+1:OW+2];
   assign pc_tag    = pcF[31:OW+IW+2];
   assign fill_idx  = base_q[OW+IW+1:OW+2];
   assign fill_tag  = base_q[31:OW+IW+2];
   assign unused_pc = ^pcF[1:0];

   assign hit      = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
   assign mem_addr = base_q + {{(30-OW){1'b0}}, k_q, 2'b00};

   // Next-state and output decode for the lookup/refill controller
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      k_d       = k_q;
      poison_d  = poison_q | inv;
      fill_ack  = 1'b0;
      fill_done = 1'b0;
      icstall   = 1'b1;
      instrF    = 32'h0000_0000;
      mem_req   = 1'b0;
      case (state_q)
         IDLE: begin
            if (hit) begin
               icstall = 1'b0;
               instrF  = data_q[pc_idx][pc_off];
            end else begin
               // latch the line base; an inv on this very edge poisons the fill
               base_d   = {pcF[31:OW+2], {(OW+2){1'b0}}};
               k_d      = '0;
               poison_d = inv;
               state_d  = FILL;
            end
         end
         FILL: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               fill_ack = 1'b1;
               k_d      = k_q + 1'b1;
               if (k_q == OW'(WORDS-1)) begin
                  fill_done = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Controller state register; reset aborts any fill in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         base_q   <= '0;
         k_q      <= '0;
         poison_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         k_q      <= k_d;
         poison_q <= poison_d;
      end
   end

   // Valid bits: inv beats a completing fill, a poisoned fill stays invalid
   always_ff @(posedge clk) begin
      if (reset || inv) begin
         valid_q <= '0;
      end else if (fill_done && !poison_q) begin
         valid_q[fill_idx] <= 1'b1;
      end
   end

   // Tag and data storage, written only by the refill (no reset needed)
   always_ff @(posedge clk) begin
      if (fill_ack) begin
         data_q[fill_idx][k_q] <= mem_rdata;
      end
      if (fill_done) begin
         tag_q[fill_idx] <= fill_tag;
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   // Free-running wrap-around hit/miss counters, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if ((state_q == IDLE) && !hit) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`else
   assign hit_count  = 32'h0000_0000;
   assign miss_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Testbench for icache_fetch: directed table, hand-written corner sequences
// and randomized fetches checked against a cache-contents reference model.
module tb_icache_fetch;
   localparam int LINES = 16;
   localparam int WORDS = 4;
   localparam int LINE_BYTES = WORDS * 4;

   logic        clk;
   logic        reset;
   logic [31:0] pcF;
   logic        inv;
   logic [31:0] instrF;
   logic        icstall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int checks = 0;
   int errors = 0;
   int waits = 0;
   bit spurious = 0;

   bit          mvalid [LINES];
   int unsigned mtag   [LINES];

   icache_fetch #(.LINES(LINES), .WORDS(WORDS)) dut (
      .clk(clk), .reset(reset), .pcF(pcF), .inv(inv),
      .instrF(instrF), .icstall(icstall),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backing memory: data = address + 0x1000, 'waits' idle cycles before each ack
   initial begin
      int wcnt;
      wcnt = 0;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            if (wcnt >= waits) begin
               mem_ack = 1'b1;
               mem_rdata = mem_addr + 32'h1000;
               wcnt = 0;
            end else begin
               mem_ack = 1'b0;
               wcnt++;
            end
         end else begin
            mem_ack = spurious;
            mem_rdata = 32'hDEAD_BEEF;
            wcnt = 0;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_perf(input int h, input int m, input string nm);
`ifdef ICACHE_PERF_EN
      chk({nm, "_hits"}, hit_count, 32'(h));
      chk({nm, "_misses"}, miss_count, 32'(m));
`else
      chk({nm, "_hits"}, hit_count, 32'h0);
      chk({nm, "_misses"}, miss_count, 32'h0);
`endif
   endtask

   task automatic model_clear();
      for (int i = 0; i < LINES; i++) begin
         mvalid[i] = 1'b0;
         mtag[i] = 0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
   endtask

   // Presents pc until one hit cycle is seen; called and returns at posedge+1.
   // inv is pulsed for the edge ending stall cycle inv_at (-1: never).
   task automatic fetch(input logic [31:0] pc, input int w, input int inv_at,
                        input int exp_stall, input logic [31:0] exp_instr,
                        input string nm);
      int st;
      int k;
      bit done;
      logic [31:0] mask;
      logic [31:0] base;
      mask = 32'(LINE_BYTES) - 32'd1;
      base = pc & ~mask;
      st = 0;
      k = 0;
      done = 1'b0;
      waits = w;
      pcF = pc;
      while (!done) begin
         inv = (st == inv_at);
         @(negedge clk); #1;
         if (mem_req) begin
            chk({nm, "_addr"}, mem_addr, base + 32'(4 * k));
            if (mem_ack) k = (k + 1) % WORDS;
         end
         if (!icstall) begin
            chk({nm, "_instr"}, instrF, exp_instr);
            done = 1'b1;
         end else if (st >= 1000) begin
            chk({nm, "_timeout"}, 32'(st), 32'(exp_stall));
            done = 1'b1;
         end else begin
            chk({nm, "_nop"}, instrF, 32'h0);
         end
         @(posedge clk); #1;
         if (!done) st++;
      end
      inv = 1'b0;
      chk({nm, "_stall"}, 32'(st), 32'(exp_stall));
   endtask

   typedef struct {
      logic [31:0] pc;
      int          w;
      int          inv_at;
      int          stall;
      logic [31:0] instr;
   } vec_t;

   vec_t tbl [13];

   initial begin
      // zero-wait miss costs 1 + WORDS stall cycles; 3 waits: 1 + 4*4 = 17
      tbl[0]  = '{32'h0000_0040, 0, -1, 5,  32'h0000_1040};
      tbl[1]  = '{32'h0000_0044, 0, -1, 0,  32'h0000_1044};
      tbl[2]  = '{32'h0000_0048, 0, -1, 0,  32'h0000_1048};
      tbl[3]  = '{32'h0000_004C, 0, -1, 0,  32'h0000_104C};
      tbl[4]  = '{32'h0000_0140, 0, -1, 5,  32'h0000_1140};
      tbl[5]  = '{32'h0000_0040, 0, -1, 5,  32'h0000_1040};
      tbl[6]  = '{32'h0000_0080, 3, -1, 17, 32'h0000_1080};
      tbl[7]  = '{32'h0000_0084, 3, -1, 0,  32'h0000_1084};
      // inv mid-fill (w=1, 9 stall cycles per fill): line refilled twice
      tbl[8]  = '{32'h0000_0200, 1, 2, 18,  32'h0000_1200};
      tbl[9]  = '{32'h0000_0040, 0, -1, 5,  32'h0000_1040};
      // inv on the fill-start edge, then inv together with the last ack
      tbl[10] = '{32'h0000_0300, 0, 0, 10,  32'h0000_1300};
      tbl[11] = '{32'h0000_0340, 0, 4, 10,  32'h0000_1340};
      tbl[12] = '{32'h0000_0340, 0, -1, 0,  32'h0000_1340};

      reset = 1'b1;
      pcF = 32'h0;
      inv = 1'b0;
      model_clear();
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk("rst_icstall", {31'h0, icstall}, 32'h1);
      chk("rst_instr", instrF, 32'h0);
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_hit_count", hit_count, 32'h0);
      chk("rst_miss_count", miss_count, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         fetch(tbl[i].pc, tbl[i].w, tbl[i].inv_at, tbl[i].stall, tbl[i].instr,
               $sformatf("row%0d", i));
         if (i == 3) chk_perf(4, 1, "perf_after_first_fill");
      end

      // spurious ack while idle on a hit: nothing may change
      pcF = 32'h0000_0340;
      spurious = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("spur_icstall", {31'h0, icstall}, 32'h0);
         chk("spur_mem_req", {31'h0, mem_req}, 32'h0);
         chk("spur_instr", instrF, 32'h0000_1340);
         @(posedge clk); #1;
      end
      spurious = 1'b0;
      fetch(32'h0000_0344, 0, -1, 0, 32'h0000_1344, "spur_after");

      // reset in the middle of a fill, with a late ack offered afterwards
      pcF = 32'h0000_0380;
      waits = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk("rmid_req_before", {31'h0, mem_req}, 32'h1);
      reset = 1'b1;
      spurious = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk("rmid_req_after", {31'h0, mem_req}, 32'h0);
      chk_perf(0, 0, "rmid_perf");
      @(posedge clk); #1;
      reset = 1'b0;
      fetch(32'h0000_0380, 0, -1, 5, 32'h0000_1380, "rmid_refetch");
      spurious = 1'b0;

      // randomized fetches against the cache-contents model
      do_reset();
      for (int n = 0; n < 150; n++) begin
         int unsigned tagv, idxv, offv;
         int w, p, inv_at, exp_st;
         bit mhit;
         logic [31:0] pc;
         tagv = $urandom_range(0, 3);
         idxv = $urandom_range(0, LINES - 1);
         offv = $urandom_range(0, WORDS - 1);
         pc = 32'(tagv * LINE_BYTES * LINES + idxv * LINE_BYTES + offv * 4);
         w = $urandom_range(0, 2);
         p = 1 + WORDS * (w + 1);
         mhit = mvalid[idxv] && (mtag[idxv] == tagv);
         inv_at = -1;
         if ($urandom_range(0, 7) == 0) inv_at = mhit ? 0 : int'($urandom_range(0, p - 1));
         exp_st = mhit ? 0 : ((inv_at >= 0) ? 2 * p : p);
         fetch(pc, w, inv_at, exp_st, pc + 32'h1000, $sformatf("rnd%0d", n));
         if (inv_at >= 0) begin
            for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
         end
         if (!mhit) begin
            mvalid[idxv] = 1'b1;
            mtag[idxv] = tagv;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
